// File: rtl/axil_lfsr_streamer.sv
// axil_lfsr_streamer: AXI-Lite configured LFSR pattern generator feeding an
// AXI-Stream master. Supports Fibonacci/Galois stepping, a programmable beat
// count with TLAST, continuous mode, STOP/abort and progress readback.
// COUNT and SENT are 32-bit registers, so C_AXIL_DATA_WIDTH must be >= 32.
// The register decode uses addr[4:2], so C_AXIL_ADDR_WIDTH must be >= 5.
module axil_lfsr_streamer #(
  parameter int                    C_AXIL_ADDR_WIDTH = 5,
  parameter int                    C_AXIL_DATA_WIDTH = 32,
  parameter int                    LFSR_WIDTH        = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS_RESET        = 16'hB400
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  // AXI-Lite write address / data / response
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  // AXI-Lite read address / data
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  // AXI-Stream master
  output logic [C_AXIL_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  localparam int DW = C_AXIL_DATA_WIDTH;
  localparam int LW = LFSR_WIDTH;

  // Register word indices (addr[4:2]); indices 6 and 7 are unmapped.
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_SEED   = 3'd2;
  localparam logic [2:0] REG_TAPS   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;
  localparam logic [2:0] REG_SENT   = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Stream FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // One LFSR advance in either topology.
  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s,
                                              input logic [LW-1:0] taps,
                                              input logic          galois);
    logic [LW-1:0] r;
    if (galois) begin
      r = (s >> 1) ^ (s[0] ? taps : '0);
    end else begin
      r = {s[LW-2:0], ^(s & taps)};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // AXI-Lite write channel
  // ---------------------------------------------------------------------
  logic          awready_q, wready_q;
  logic          aw_cap_q, w_cap_q;
  logic [2:0]    awidx_q;
  logic [DW-1:0] wdata_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          aw_hs, w_hs, do_write;

  assign aw_hs    = awready_q & s_axi_awvalid;
  assign w_hs     = wready_q & s_axi_wvalid;
  // Both halves of the write are in hand and no response is pending.
  assign do_write = aw_cap_q & w_cap_q & ~bvalid_q;

  // Capture AW and W independently, then issue one response per write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= s_axi_awvalid & ~aw_cap_q & ~awready_q & ~bvalid_q;
      wready_q  <= s_axi_wvalid & ~w_cap_q & ~wready_q & ~bvalid_q;
      if (aw_hs) begin
        aw_cap_q <= 1'b1;
        awidx_q  <= s_axi_awaddr[4:2];
      end else if (do_write) begin
        aw_cap_q <= 1'b0;
      end
      if (w_hs) begin
        w_cap_q <= 1'b1;
        wdata_q <= s_axi_wdata;
      end else if (do_write) begin
        w_cap_q <= 1'b0;
      end
      if (do_write) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (awidx_q > REG_SENT) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

  // CTRL pulses; STOP takes priority over a simultaneous START.
  logic ctrl_wr, start_req, stop_req;
  assign ctrl_wr   = do_write & (awidx_q == REG_CTRL);
  assign start_req = ctrl_wr & wdata_q[0] & ~wdata_q[1];
  assign stop_req  = ctrl_wr & wdata_q[1];

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  logic          mode_q, cont_q;
  logic [LW-1:0] seed_q, taps_q;
  logic [31:0]   count_q;

  // Software-visible configuration; running bursts use their own copies.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q  <= 1'b0;
      cont_q  <= 1'b0;
      seed_q  <= {{(LW-1){1'b0}}, 1'b1};
      taps_q  <= TAPS_RESET;
      count_q <= '0;
    end else if (do_write) begin
      case (awidx_q)
        REG_CTRL: begin
          mode_q <= wdata_q[2];
          cont_q <= wdata_q[3];
        end
        REG_SEED:  seed_q  <= wdata_q[LW-1:0];
        REG_TAPS:  taps_q  <= wdata_q[LW-1:0];
        REG_COUNT: count_q <= wdata_q[31:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stream FSM
  // ---------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] lfsr_q, lfsr_d;
  logic [31:0]   sent_q, sent_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          wmode_q, wmode_d;
  logic          wcont_q, wcont_d;
  logic [LW-1:0] wtaps_q, wtaps_d;
  logic [31:0]   wcount_q, wcount_d;
  logic          busy, tvalid, beat_hs, is_last;

  assign busy    = (state_q != ST_IDLE);
  assign tvalid  = busy;
  assign beat_hs = tvalid & m_axis_tready;
  assign is_last = ~wcont_q & (sent_q == (wcount_q - 32'd1));

  // Next-state logic: burst start, beat accounting and stop handling.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    sent_d    = sent_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    wmode_d   = wmode_q;
    wcont_d   = wcont_q;
    wtaps_d   = wtaps_q;
    wcount_d  = wcount_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          sent_d    = '0;
          if (!wdata_q[3] && (count_q == 32'd0)) begin
            // Empty burst: completes immediately without any beat.
            done_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            lfsr_d   = (seed_q == '0) ? {{(LW-1){1'b0}}, 1'b1} : seed_q;
            wmode_d  = wdata_q[2];
            wcont_d  = wdata_q[3];
            wtaps_d  = taps_q;
            wcount_d = count_q;
          end
        end
      end
      ST_RUN: begin
        if (beat_hs) begin
          sent_d = sent_q + 32'd1;
          lfsr_d = lfsr_step(lfsr_q, wtaps_q, wmode_q);
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (stop_req) begin
            // The presented beat was taken in the same cycle as STOP.
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
          end
        end else if (stop_req) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (beat_hs) begin
          sent_d    = sent_q + 32'd1;
          lfsr_d    = lfsr_step(lfsr_q, wtaps_q, wmode_q);
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and working-copy registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= '0;
      sent_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wmode_q   <= 1'b0;
      wcont_q   <= 1'b0;
      wtaps_q   <= '0;
      wcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      sent_q    <= sent_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wmode_q   <= wmode_d;
      wcont_q   <= wcont_d;
      wtaps_q   <= wtaps_d;
      wcount_q  <= wcount_d;
    end
  end

  assign m_axis_tvalid = tvalid;
  assign m_axis_tlast  = tvalid & is_last;

  generate
    if (DW > LW) begin : g_tdata_ext
      assign m_axis_tdata = {{(DW-LW){1'b0}}, lfsr_q};
    end else begin : g_tdata_full
      assign m_axis_tdata = lfsr_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // AXI-Lite read channel
  // ---------------------------------------------------------------------
  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          ar_hs;

  assign ar_hs = arready_q & s_axi_arvalid;

  // Read mux over the register file; unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (s_axi_araddr[4:2])
      REG_CTRL:   rd_data[3:2]    = {cont_q, mode_q};
      REG_STATUS: rd_data[2:0]    = {aborted_q, done_q, busy};
      REG_SEED:   rd_data[LW-1:0] = seed_q;
      REG_TAPS:   rd_data[LW-1:0] = taps_q;
      REG_COUNT:  rd_data[31:0]   = count_q;
      REG_SENT:   rd_data[31:0]   = sent_q;
      default:    rd_err          = 1'b1;
    endcase
  end

  // Accept one read at a time and hold the data until it is taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= s_axi_arvalid & ~arready_q & ~rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  // Byte-lane address bits carry no meaning for full-word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

endmodule

// File: doc/axil_lfsr_streamer.md
# axil_lfsr_streamer

Parametrised AXI-Lite-configured LFSR pattern generator driving an AXI-Stream master. It generalises the 8-bit single-mode generator to a configurable LFSR width with Fibonacci/Galois mode and a programmable beat count with TLAST. It adds stop/abort handling, status/progress readback and SLVERR on unmapped addresses. It sits behind the AXI-Lite control interconnect and feeds stream consumers such as FIFOs, DMA engines and checkers.

## Interface
- C_AXIL_ADDR_WIDTH, 5: AXI-Lite address width; decode uses addr[4:2], addr[1:0] ignored.
- C_AXIL_DATA_WIDTH, 32: AXI-Lite and AXI-Stream data width.
- LFSR_WIDTH, 16: LFSR state width, legal range 2..C_AXIL_DATA_WIDTH.
- TAPS_RESET, 16'hB400: reset value of TAPS, LFSR_WIDTH bits.
- aclk in 1: single clock for all logic.
- aresetn in 1: reset, asynchronous, active-low.
- s_axi_awaddr/awvalid/awready, s_axi_wdata/wvalid/wready, s_axi_bresp[1:0]/bvalid/bready: AXI-Lite write channels (no WSTRB, full-word writes).
- s_axi_araddr/arvalid/arready, s_axi_rdata/rresp[1:0]/rvalid/rready: AXI-Lite read channels.
- m_axis_tdata out C_AXIL_DATA_WIDTH: LFSR state, zero-extended.
- m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tlast out 1: stream handshake and end of burst.

## Operation
- Register map:
  - 0x00 CTRL: bit0 START (W1 pulse, reads 0), bit1 STOP (W1 pulse, reads 0), bit2 MODE (0 Fibonacci, 1 Galois), bit3 CONT (ignore COUNT).
  - 0x04 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ABORTED.
  - 0x08 SEED, LFSR_WIDTH bits, reset 1.
  - 0x0C TAPS, reset TAPS_RESET.
  - 0x10 COUNT, 32 bits, reset 0.
  - 0x14 SENT (RO): beats accepted since last start.
- Writes to STATUS/SENT are ignored with OKAY. Addresses 0x18 and above return SLVERR (2'b10) on read and write; reads there return 0 and writes are dropped.
- SEED, TAPS, MODE, CONT and COUNT are latched into working copies on START. Register writes while BUSY change the registers only, not the running burst.
- A SEED of 0 is latched as 1, which prevents lock-up.
- Step functions:
  - Fibonacci: s' = {s[W-2:0], ^(s & taps)}.
  - Galois: s' = (s >> 1) ^ (s[0] ? taps : 0).
- The state advances only on a stream handshake (tvalid & tready). The first beat is the latched seed.
- FSM states:
  - IDLE: leaves on START. If CONT=0 and COUNT=0, goes straight to IDLE with DONE=1 and emits no beats. Otherwise goes to RUN, clears DONE, ABORTED and SENT, and sets BUSY.
  - RUN: tvalid is high. On each handshake, SENT increments and the LFSR steps. tlast=1 on the beat where SENT == COUNT-1 (never when CONT=1). The handshake of the tlast beat moves the FSM to IDLE with DONE=1.
  - STOP_PEND: entered from RUN on STOP. The presented beat is held unchanged (tdata and tlast stable) until its handshake, then the FSM goes to IDLE with ABORTED=1 and DONE=0.
- START while BUSY is ignored. START and STOP in the same write: STOP wins and no burst starts. STOP while IDLE is a no-op.
- When CONT=1, SENT wraps modulo 2^32.

## Timing
- Reset: all outputs are 0 (awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, tvalid, tdata, tlast). The FSM is in IDLE.
- Write: AW and W are captured independently. awready and wready are each a registered one-cycle pulse, asserted the cycle after the corresponding valid is seen, provided that channel is not yet captured and bvalid is low.
- Write response: the register update and bvalid happen in the cycle after both channels are captured. bvalid/bresp are held until bready. Only one write is outstanding at a time.
- Read: arready is a one-cycle registered pulse when arvalid is high and no read is outstanding. rvalid/rdata/rresp appear the cycle after the AR handshake and are held until rready.
- START latency: if the write update happens in cycle T, tvalid=1 with tdata=seed from cycle T+1.
- Stream: once asserted, tvalid never drops without a handshake. There is back-to-back throughput of one beat per cycle while tready=1. tvalid falls the cycle after the final handshake.
- Asynchronous reset mid-burst: tvalid drops immediately and all registers return to their reset values.

## Test plan
- Reset → every output 0; reading SEED gives 0x1, TAPS gives 0xB400, STATUS gives 0.
- Galois, SEED=0x0001, TAPS=0xB400, COUNT=4, tready=1 → tdata 0x0001, 0xB400, 0x5A00, 0x2D00; tlast on the 4th beat only; STATUS=0x2; SENT=4.
- Fibonacci, SEED=0, COUNT=3 → tdata 0x0001, 0x0002, 0x0004.
- Galois, COUNT=8, tready toggled 1/0 every cycle → tdata/tlast stable while stalled; sequence identical to the unstalled run.
- CONT=1, STOP written while tready=0 → held beat completes on tready, then tvalid=0; STATUS=0x4; tlast never seen.
- Write to 0x18 → bresp=2'b10; read of 0x1C → rresp=2'b10 with rdata=0; COUNT=0 with START → STATUS=0x2 and no beats.
